// File: rtl/alex_spi_tx.sv
// Alex filter-board SPI transmitter: shifts {HPF, LPF, atten, preamp} MSB first, then pulses the load strobe.
// Optional feature macro: ALEX_PERIODIC_REFRESH_EN (periodic resend of an unchanged word).
module alex_spi_tx #(
  parameter int unsigned CLK_DIV        = 4,
  parameter logic [23:0] REFRESH_CYCLES = 24'd12_288_000
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic [5:0] HPF,
  input  logic [6:0] LPF,
  input  logic [1:0] atten,
  input  logic       preamp,
  output logic       SPI_data,
  output logic       SPI_clock,
  output logic       Rx_load_strobe,
  output logic       busy
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SHIFT_LO = 2'd1;
  localparam logic [1:0] ST_SHIFT_HI = 2'd2;
  localparam logic [1:0] ST_STROBE   = 2'd3;
  localparam logic [7:0] DIV_LAST    = 8'(CLK_DIV - 1);

  logic [15:0] word_s;
  logic [1:0]  state_r, state_s;
  logic [15:0] last_sent_r;
  logic        sent_valid_r;
  logic [15:0] shift_reg_r, shift_s;
  logic [4:0]  bit_cnt_r, bit_cnt_s;
  logic [7:0]  div_cnt_r, div_cnt_s;
  logic        change_s, start_s, load_s, div_done_s;

  assign word_s     = {HPF, LPF, atten, preamp};
  assign change_s   = (word_s != last_sent_r) || !sent_valid_r;
  assign div_done_s = (div_cnt_r == DIV_LAST);

`ifdef ALEX_PERIODIC_REFRESH_EN
  logic [23:0] idle_cnt_r;

  assign start_s = change_s || (idle_cnt_r == (REFRESH_CYCLES - 24'd1));

  // Idle timer: counts quiet IDLE cycles, cleared whenever a transfer is launched or running
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_r <= 24'd0;
    end else if ((state_r == ST_IDLE) && !start_s) begin
      idle_cnt_r <= idle_cnt_r + 24'd1;
    end else begin
      idle_cnt_r <= 24'd0;
    end
  end
`else
  assign start_s = change_s;
`endif

  // Next-state logic: each non-idle state lasts CLK_DIV cycles
  always_comb begin
    state_s   = state_r;
    shift_s   = shift_reg_r;
    bit_cnt_s = bit_cnt_r;
    div_cnt_s = div_cnt_r;
    load_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        div_cnt_s = 8'd0;
        if (start_s) begin
          state_s   = ST_SHIFT_LO;
          shift_s   = word_s;
          bit_cnt_s = 5'd0;
          load_s    = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT_LO: begin
        if (div_done_s) begin
          div_cnt_s = 8'd0;
          state_s   = ST_SHIFT_HI;
        end else begin
          div_cnt_s = div_cnt_r + 8'd1;
        end
      end
      ST_SHIFT_HI: begin
        if (div_done_s) begin
          div_cnt_s = 8'd0;
          shift_s   = {shift_reg_r[14:0], 1'b0};
          bit_cnt_s = bit_cnt_r + 5'd1;
          state_s   = (bit_cnt_r == 5'd15) ? ST_STROBE : ST_SHIFT_LO;
        end else begin
          div_cnt_s = div_cnt_r + 8'd1;
        end
      end
      ST_STROBE: begin
        if (div_done_s) begin
          div_cnt_s = 8'd0;
          state_s   = ST_IDLE;
        end else begin
          div_cnt_s = div_cnt_r + 8'd1;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        div_cnt_s = 8'd0;
      end
    endcase
  end

  // State, shifter and sent-word bookkeeping
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      shift_reg_r  <= 16'd0;
      bit_cnt_r    <= 5'd0;
      div_cnt_r    <= 8'd0;
      last_sent_r  <= 16'd0;
      sent_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      shift_reg_r <= shift_s;
      bit_cnt_r   <= bit_cnt_s;
      div_cnt_r   <= div_cnt_s;
      if (load_s) begin
        last_sent_r  <= word_s;
        sent_valid_r <= 1'b1;
      end
    end
  end

  // Outputs are registered from the next state so they switch together with it
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      SPI_data       <= 1'b0;
      SPI_clock      <= 1'b0;
      Rx_load_strobe <= 1'b0;
      busy           <= 1'b0;
    end else begin
      SPI_data       <= ((state_s == ST_SHIFT_LO) || (state_s == ST_SHIFT_HI)) ? shift_s[15] : 1'b0;
      SPI_clock      <= (state_s == ST_SHIFT_HI);
      Rx_load_strobe <= (state_s == ST_STROBE);
      busy           <= (state_s != ST_IDLE);
    end
  end

endmodule

// File: doc/alex_spi_tx.md
# alex_spi_tx

Serialises the Alex filter-board control word (HPF select, LPF select, attenuator and preamp bits) onto the three-wire Alex SPI bus. It sits directly downstream of the HPF/LPF band decoders: it consumes their steady-state select vectors and shifts them to the Alex shift registers, ending each transfer with a load strobe. A transfer happens on any change of the assembled word, and also once after reset.

## Interface
- CLK_DIV, default 4: system cycles per SPI_clock half-period (legal range 2..255).
- REFRESH_CYCLES, default 24'd12_288_000: idle interval before a forced resend. Only used when ALEX_PERIODIC_REFRESH_EN is defined.
- clock  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- HPF  in  6  one-hot HPF select from the band decoder
- LPF  in  7  one-hot LPF select from the band decoder
- atten  in  2  attenuator bits (10 dB, 20 dB)
- preamp  in  1  preamp enable
- SPI_data  out  1  serial data, MSB first
- SPI_clock  out  1  serial clock; data is sampled by Alex on the rising edge
- Rx_load_strobe  out  1  active-high latch pulse after bit 0
- busy  out  1  high while a transfer or strobe is in progress

## Operation
- Word assembly: word[15:0] = {HPF[5:0], LPF[6:0], atten[1:0], preamp}. Bit 15 is shifted first.
- Registered state: last_sent[15:0], sent_valid, shift_reg[15:0], bit_cnt[4:0], div_cnt[7:0].
- FSM states:
  - IDLE: outputs low. Move to SHIFT_LO when word != last_sent or sent_valid == 0. On that transition, load shift_reg = word and last_sent = word, set sent_valid = 1, and clear bit_cnt = 0.
  - SHIFT_LO: SPI_clock = 0 and SPI_data = shift_reg[15]. After CLK_DIV cycles, go to SHIFT_HI.
  - SHIFT_HI: SPI_clock = 1 and SPI_data is held. After CLK_DIV cycles:
    - Shift shift_reg left by 1 and increment bit_cnt.
    - If bit_cnt was 15, go to STROBE; otherwise go to SHIFT_LO.
  - STROBE: SPI_clock = 0, SPI_data = 0, Rx_load_strobe = 1. After CLK_DIV cycles, go to IDLE.
- Input changes during a transfer are not merged into it; the shift register holds the latched word.
- On return to IDLE, the compare against last_sent is re-evaluated. A changed word therefore starts a new transfer on the very next cycle.
- Input glitches shorter than one transfer may cause one extra transfer. No input debouncing is performed.
- Reset mid-transfer: all outputs go low immediately, sent_valid is cleared, and the FSM goes to IDLE. A full transfer follows after reset release.

## Timing
- Reset values:
  - SPI_data = 0, SPI_clock = 0, Rx_load_strobe = 0, busy = 0.
  - last_sent = 0, sent_valid = 0, FSM = IDLE.
- Trigger latency: busy and the first SPI_data bit are registered one cycle after the cycle in which the compare is true in IDLE.
- Transfer length: busy is high for exactly 33*CLK_DIV cycles (16 bits × 2 half-periods + 1 strobe period). With CLK_DIV = 4 this is 132 cycles.
- Setup and hold: SPI_data changes only on entry to SHIFT_LO. This gives CLK_DIV cycles of setup before the rising edge and CLK_DIV cycles of hold after it.
- SPI_clock produces exactly 16 rising edges per transfer. Rx_load_strobe never overlaps SPI_clock high.
- Minimum gap between transfers: 1 IDLE cycle.

## Configuration
- ALEX_PERIODIC_REFRESH_EN defined:
  - A 24-bit idle counter increments while in IDLE with no change pending, and clears on leaving IDLE.
  - When it reaches REFRESH_CYCLES-1, the FSM starts a transfer of the unchanged word. This recovers Alex after hot-plug or a power glitch.
  - A word change takes precedence over the refresh and clears the counter.
- ALEX_PERIODIC_REFRESH_EN undefined: no counter is present, and transfers occur only after reset and on word change.

## Test plan
- Reset release with HPF = 6'b100000, LPF = 7'b0000001, atten = 0, preamp = 0:
  - One transfer of 16'h8008, shifted MSB first.
  - Rx_load_strobe high for 4 cycles; busy high for 132 cycles.
  - No further activity over 10,000 idle cycles (macro undefined).
- HPF changes from 6'b010000 to 6'b000001 while idle:
  - Transfer starts 1 cycle later.
  - Captured bits at the 16 rising edges equal the new word.
- Change LPF at cycle 40 of a transfer:
  - The current transfer completes with the old word.
  - The second transfer starts 1 cycle after busy falls and carries the new word.
- Assert rst_n low at bit 7 of a transfer:
  - All outputs go to 0 within the same cycle.
  - After release, a complete 16-bit transfer plus strobe occurs with the current word.
- With ALEX_PERIODIC_REFRESH_EN and REFRESH_CYCLES = 1000, inputs static:
  - Transfers repeat with exactly 1000 idle cycles between busy falling and the next busy rising.
  - Each repeat carries an identical word.
- CLK_DIV = 2:
  - SPI_clock period is 4 cycles and busy lasts 66 cycles.
  - SPI_data is stable for 2 cycles before and 2 cycles after every rising edge.
